hazard_stall_controller: RTL

- Pipeline control for the five-stage core.
- Detects load-use, MAC structural and accumulator hazards, and drives PC/fetch-decode write enables and bubble/flush requests around the decode-to-execute register.
- Generates operand forwarding selects for execute.
- Tracks the in-flight multi-cycle MAC with a state machine and latency counter.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_stall_controller_forwarding_unit.sv | 34 +++
 rtl/hazard_stall_controller.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and constants for the pipeline hazard/stall controller.
//   - mac_state_e      : MAC occupancy state (RUN, MAC_BUSY)
//   - FWD_*            : execute operand forwarding select encodings
//   - mac_count_width  : width needed to hold a MAC latency countdown
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MAC_BUSY = 1'b1
  } mac_state_e;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] FWD_WB      = 2'b01;

  // Countdown holds at most MAC_LATENCY-1; never narrower than one bit.
  function automatic int mac_count_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/hazard_stall_controller_forwarding_unit.sv
// forwarding_unit
//   Purely combinational operand forwarding select for one execute operand.
//   Ports:
//     ex_rs   : execute-stage source register index
//     mem_rd  : memory-stage destination index
//     mem_we  : memory-stage register write enable
//     wb_rd   : writeback-stage destination index
//     wb_we   : writeback-stage register write enable
//     fwd_sel : FWD_MEM, FWD_WB or FWD_REGFILE (memory stage has priority)
module forwarding_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_we,
  output logic [1:0]            fwd_sel
);

  // The memory stage holds the younger result, so it wins over writeback.
  // Register 0 is hardwired zero and is never forwarded.
  always_comb begin
    fwd_sel = FWD_REGFILE;
    if (mem_we && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      fwd_sel = FWD_MEM;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//   Pipeline control for the five-stage core: load-use and MAC hazard
//   detection, PC / fetch-decode write enables, bubble and flush requests,
//   operand forwarding selects, and tracking of the in-flight MAC.
//   Ports:
//     clock, reset (asynchronous, active-low)
//     id*   : decode-stage operand usage and MAC / accumulator flags
//     ex*   : execute-stage indices, load flag, taken branch/jump
//     mem*, wb* : downstream destinations and write enables
//     pcWriteEnable, fetchDecodeWriteEnable : pipeline advance enables
//     fetchDecodeFlush, decodeExecuteFlush  : flush / bubble requests
//     forwardA, forwardB : execute operand select (00 rf, 10 mem, 01 wb)
//     macBusy            : MAC unit occupied
//   Optional: define HAZARD_PERF_COUNT_EN to add saturating stallCycles and
//   flushCycles counter outputs.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MAC_LATENCY = 3,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic                  idUsesRs1,
  input  logic                  idUsesRs2,
  input  logic                  idIsMac,
  input  logic                  idUsesAccum,
  input  logic [REG_ADDR_W-1:0] exRs1,
  input  logic [REG_ADDR_W-1:0] exRs2,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic                  exMemoryReadEnable,
  input  logic                  exPcUpdate,
  input  logic [REG_ADDR_W-1:0] memRd,
  input  logic                  memRegisterWriteEnable,
  input  logic [REG_ADDR_W-1:0] wbRd,
  input  logic                  wbRegisterWriteEnable,
  output logic                  pcWriteEnable,
  output logic                  fetchDecodeWriteEnable,
  output logic                  fetchDecodeFlush,
  output logic                  decodeExecuteFlush,
  output logic [1:0]            forwardA,
  output logic [1:0]            forwardB,
  output logic                  macBusy
`ifdef HAZARD_PERF_COUNT_EN
  ,
  output logic [31:0]           stallCycles,
  output logic [31:0]           flushCycles
`endif
);

  localparam int CNT_W = mac_count_width(MAC_LATENCY);
  localparam logic [CNT_W-1:0] MAC_RELOAD = CNT_W'(MAC_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  mac_state_e       state_q, state_d;
  logic [CNT_W-1:0] mac_count_q, mac_count_d;
  logic             mac_busy_q, mac_busy_d;

  logic       load_use;
  logic       mac_hazard;
  logic       stall;
  logic       issue_mac;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_rs   (exRs1),
    .mem_rd  (memRd),
    .mem_we  (memRegisterWriteEnable),
    .wb_rd   (wbRd),
    .wb_we   (wbRegisterWriteEnable),
    .fwd_sel (fwd_a_raw)
  );

  forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_rs   (exRs2),
    .mem_rd  (memRd),
    .mem_we  (memRegisterWriteEnable),
    .wb_rd   (wbRd),
    .wb_we   (wbRegisterWriteEnable),
    .fwd_sel (fwd_b_raw)
  );

  // A load in execute cannot forward in time for a dependent decode
  // instruction; a busy MAC blocks any instruction touching the MAC or the
  // accumulator. Both collapse into one stall.
  always_comb begin
    load_use   = exMemoryReadEnable && (exRd != '0) &&
                 ((idUsesRs1 && (exRd == idRs1)) ||
                  (idUsesRs2 && (exRd == idRs2)));
    mac_hazard = (state_q == MAC_BUSY) && (idIsMac || idUsesAccum);
    stall      = load_use || mac_hazard;
    issue_mac  = idIsMac && !stall && !exPcUpdate;
  end

  // Pipeline control priority: reset, then redirect flush, then stall.
  // Reset is folded in so the pipeline is held and flushed while reset is low.
  always_comb begin
    pcWriteEnable          = 1'b1;
    fetchDecodeWriteEnable = 1'b1;
    fetchDecodeFlush       = 1'b0;
    decodeExecuteFlush     = 1'b0;
    forwardA               = fwd_a_raw;
    forwardB               = fwd_b_raw;
    if (!reset) begin
      pcWriteEnable          = 1'b0;
      fetchDecodeWriteEnable = 1'b0;
      fetchDecodeFlush       = 1'b1;
      decodeExecuteFlush     = 1'b1;
      forwardA               = FWD_REGFILE;
      forwardB               = FWD_REGFILE;
    end else if (exPcUpdate) begin
      fetchDecodeFlush   = 1'b1;
      decodeExecuteFlush = 1'b1;
    end else if (stall) begin
      pcWriteEnable          = 1'b0;
      fetchDecodeWriteEnable = 1'b0;
      decodeExecuteFlush     = 1'b1;
    end
  end

  // MAC occupancy. The countdown ignores stalls and flushes: an issued MAC
  // is older than any branch resolving in execute, so it always completes.
  // With MAC_LATENCY of 1 the unit is never reported busy.
  always_comb begin
    state_d     = state_q;
    mac_count_d = mac_count_q;
    case (state_q)
      RUN: begin
        if (issue_mac && (MAC_LATENCY > 1)) begin
          state_d     = MAC_BUSY;
          mac_count_d = MAC_RELOAD;
        end
      end
      MAC_BUSY: begin
        if (mac_count_q <= CNT_ONE) begin
          state_d     = RUN;
          mac_count_d = '0;
        end else begin
          mac_count_d = mac_count_q - CNT_ONE;
        end
      end
      default: begin
        state_d     = RUN;
        mac_count_d = '0;
      end
    endcase
    mac_busy_d = (state_d == MAC_BUSY);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      mac_count_q <= '0;
      mac_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mac_count_q <= mac_count_d;
      mac_busy_q  <= mac_busy_d;
    end
  end

  assign macBusy = mac_busy_q;

`ifdef HAZARD_PERF_COUNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_cycles_q, flush_cycles_d;

  // Saturating counters; a flush cycle is never also counted as a stall.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    if (stall && !exPcUpdate && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (exPcUpdate && (flush_cycles_q != 32'hFFFF_FFFF)) begin
      flush_cycles_d = flush_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign stallCycles = stall_cycles_q;
  assign flushCycles = flush_cycles_q;
`endif

endmodule
